// File: rtl/lfo_pkg.sv
// Shared constants, FSM state type and address-bit helper for the ADC SPI reader.
package lfo_pkg;

  localparam int ADC_FRAME_BITS = 16;
  localparam int ADC_DATA_BITS  = 12;
  localparam int ADC_ADDR_FIRST = 2;
  localparam int ADC_ADDR_BITS  = 3;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    DONE,
    GAP
  } adc_state_t;

  // Channel address goes out MSB first in bit periods 2..4; every other period sends 0.
  function automatic logic addr_bit(input logic [3:0] k, input logic [2:0] ch);
    case (k)
      4'd2:    return ch[2];
      4'd3:    return ch[1];
      4'd4:    return ch[0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/adc_interface_spi_half_timer.sv
// Half-period timer: a down-counter that ticks for one cycle at the end of each SCLK half-period.
module spi_half_timer #(
  parameter int HALF_PER = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;
  localparam logic [CW-1:0] LOAD = CW'(HALF_PER - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == '0);

  // Reload on clear so the first half-period after a state change is full length.
  always_comb begin
    cnt_d = cnt_q - 1'b1;
    if (clear_i || tick_o) cnt_d = LOAD;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/adc_interface.sv
// SPI master reading one 16-SCLK frame from an 8-channel 12-bit ADC per start request.
// state | meaning
// IDLE  | CS high, waiting for start
// SETUP | CS low, SCLK high, CS-to-first-fall setup time
// SHIFT | 16 SCLK periods: address out on DIN, data in on DOUT
// DONE  | one cycle, publish result with valid
// GAP   | CS high minimum time before the next frame
module adc_interface
  import lfo_pkg::*;
#(
  parameter int HALF_PER = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  chan,
  output logic        busy,
  output logic        valid,
  output logic [11:0] data,
  output logic [2:0]  data_chan,
  output logic        fmt_err,
  output logic        ADC_CS_N,
  output logic        ADC_SCLK,
  output logic        ADC_DIN,
  input  logic        ADC_DOUT
);

  adc_state_t state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [ADC_FRAME_BITS-1:0] shift_q, shift_d;
  logic [2:0]  cur_chan_q, cur_chan_d;
  logic [2:0]  prev_chan_q, prev_chan_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic [ADC_DATA_BITS-1:0] data_q, data_d;
  logic [2:0]  data_chan_q, data_chan_d;
  logic        fmt_err_q, fmt_err_d;
  logic        cs_n_q, cs_n_d;
  logic        sclk_q, sclk_d;
  logic        din_q, din_d;
  logic        tick;
  logic        timer_clear;

  spi_half_timer #(.HALF_PER(HALF_PER)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (timer_clear),
    .tick_o  (tick)
  );

  assign timer_clear = (state_d != state_q);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    cur_chan_d  = cur_chan_q;
    prev_chan_d = prev_chan_q;
    busy_d      = busy_q;
    valid_d     = 1'b0;
    data_d      = data_q;
    data_chan_d = data_chan_q;
    fmt_err_d   = fmt_err_q;
    cs_n_d      = cs_n_q;
    sclk_d      = sclk_q;
    din_d       = din_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SETUP;
          cur_chan_d = chan;
          cs_n_d     = 1'b0;
          busy_d     = 1'b1;
          bit_cnt_d  = '0;
        end
      end
      SETUP: begin
        if (tick) begin
          state_d = SHIFT;
          sclk_d  = 1'b0;
          din_d   = addr_bit(bit_cnt_q, cur_chan_q);
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!sclk_q) begin
            // Rising SCLK: ADC drove this bit on the previous fall, so it is stable now.
            sclk_d  = 1'b1;
            shift_d = {shift_q[ADC_FRAME_BITS-2:0], ADC_DOUT};
          end else if (bit_cnt_q == 4'(ADC_FRAME_BITS - 1)) begin
            state_d     = DONE;
            cs_n_d      = 1'b1;
            din_d       = 1'b0;
            valid_d     = 1'b1;
            data_d      = shift_q[ADC_DATA_BITS-1:0];
            fmt_err_d   = |shift_q[ADC_FRAME_BITS-1:ADC_DATA_BITS];
            // The ADC converts the channel addressed in the previous frame.
            data_chan_d = prev_chan_q;
            prev_chan_d = cur_chan_q;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            sclk_d    = 1'b0;
            din_d     = addr_bit(bit_cnt_q + 4'd1, cur_chan_q);
          end
        end
      end
      DONE: begin
        state_d = GAP;
      end
      GAP: begin
        if (tick) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      cur_chan_q  <= '0;
      prev_chan_q <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      data_chan_q <= '0;
      fmt_err_q   <= 1'b0;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b1;
      din_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      cur_chan_q  <= cur_chan_d;
      prev_chan_q <= prev_chan_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      data_chan_q <= data_chan_d;
      fmt_err_q   <= fmt_err_d;
      cs_n_q      <= cs_n_d;
      sclk_q      <= sclk_d;
      din_q       <= din_d;
    end
  end

  assign busy      = busy_q;
  assign valid     = valid_q;
  assign data      = data_q;
  assign data_chan = data_chan_q;
  assign fmt_err   = fmt_err_q;
  assign ADC_CS_N  = cs_n_q;
  assign ADC_SCLK  = sclk_q;
  assign ADC_DIN   = din_q;

endmodule

// File: tb/tb_adc_interface.sv
// Scoreboard bench for adc_interface with HALF_PER=2 and a behavioural ADC128S022-style slave.
module tb_adc_interface;

  localparam int HP = 2;
  localparam int FRAME_PERIOD = 34 * HP + 2;
  // Valid appears in the interval following edge t+33*HP (cycle t+33*HP+1 in 1-based counting).
  localparam int VALID_LAT = 33 * HP;
  localparam int BUSY_LEN = 34 * HP + 1;

  logic clk = 1'b0;
  logic reset_n, start, adc_dout;
  logic [2:0] chan;
  logic busy, valid, fmt_err, ADC_CS_N, ADC_SCLK, ADC_DIN;
  logic [11:0] data;
  logic [2:0] data_chan;

  adc_interface #(.HALF_PER(HP)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .chan      (chan),
    .busy      (busy),
    .valid     (valid),
    .data      (data),
    .data_chan (data_chan),
    .fmt_err   (fmt_err),
    .ADC_CS_N  (ADC_CS_N),
    .ADC_SCLK  (ADC_SCLK),
    .ADC_DIN   (ADC_DIN),
    .ADC_DOUT  (adc_dout)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [11:0] d;
    logic [2:0]  c;
    logic        f;
    int          cy;
  } exp_t;
  exp_t sb[$];

  logic armed = 1'b0;
  logic abort = 1'b0;
  logic held_chk = 1'b0;

  // ADC model: shifts the word out MSB first on SCLK falls, samples address on rises 2..4.
  logic [15:0] model_word = '0;
  logic [2:0]  model_addr = '0;
  logic [2:0]  exp_addr = '0;
  int fall_k = 0;
  int rise_k = 0;
  initial adc_dout = 1'b0;

  always @(negedge ADC_CS_N) if (armed) begin
    fall_k = 0;
    rise_k = 0;
    model_addr = '0;
  end
  always @(negedge ADC_SCLK) if (armed && ADC_CS_N === 1'b0 && fall_k < 16) begin
    adc_dout = model_word[15 - fall_k];
    fall_k++;
  end
  always @(posedge ADC_SCLK) if (armed && ADC_CS_N === 1'b0) begin
    if (rise_k >= 2 && rise_k <= 4) model_addr = {model_addr[1:0], ADC_DIN};
    rise_k++;
  end
  always @(posedge ADC_CS_N) if (armed && !abort) begin
    chk("sclk_rises_per_frame", rise_k, 16);
    chk("model_addr", model_addr, exp_addr);
  end

  // Monitor: pops the scoreboard on valid, plus framing checks on CS/SCLK/busy.
  logic cs_prev = 1'b1;
  logic busy_prev = 1'b0;
  int busy_cnt = 0;
  int cs_falls = 0;
  int last_fall = 0;
  int held_n = 0;
  int sclk_viol = 0;

  always @(negedge clk) if (armed) begin
    if (valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("data", data, e.d);
        chk("data_chan", data_chan, e.c);
        chk("fmt_err", fmt_err, e.f);
        chk("valid_cycle", cyc, e.cy);
      end
    end
    if (ADC_CS_N && !ADC_SCLK) sclk_viol++;
    if (cs_prev && !ADC_CS_N) begin
      cs_falls++;
      if (held_chk) begin
        if (held_n > 0) chk("cs_fall_period", cyc - last_fall, FRAME_PERIOD);
        held_n++;
      end
      last_fall = cyc;
    end
    cs_prev = ADC_CS_N;
    if (busy) busy_cnt++;
    else if (busy_prev) begin
      if (!abort) chk("busy_length", busy_cnt, BUSY_LEN);
      busy_cnt = 0;
    end
    busy_prev = busy;
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("wait_idle_timeout", 1, 0);
  endtask

  task automatic start_frame(input logic [2:0] ch, input logic [15:0] w, input logic [11:0] ed,
                             input logic [2:0] edc, input logic efmt, input logic push,
                             output int acc);
    exp_t e;
    wait_idle();
    model_word = w;
    exp_addr = ch;
    chan = ch;
    start = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    start = 1'b0;
    if (push) begin
      e.d = ed; e.c = edc; e.f = efmt; e.cy = acc + VALID_LAT;
      sb.push_back(e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int acc, falls0, n;
    exp_t e;
    reset_n = 1'b0;
    start = 1'b0;
    chan = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_data_chan", data_chan, 0);
    chk("rst_fmt_err", fmt_err, 0);
    chk("rst_cs_n", ADC_CS_N, 1);
    chk("rst_sclk", ADC_SCLK, 1);
    chk("rst_din", ADC_DIN, 0);
    reset_n = 1'b1;
    armed = 1'b1;

    // First frame after reset reports channel 0 regardless of request.
    start_frame(3'd5, 16'h0A53, 12'hA53, 3'd0, 1'b0, 1'b1, acc);
    start_frame(3'd2, 16'h0FFF, 12'hFFF, 3'd5, 1'b0, 1'b1, acc);

    // start held high: three back-to-back frames on channel 3.
    wait_idle();
    model_word = 16'h0321;
    exp_addr = 3'd3;
    chan = 3'd3;
    held_chk = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    e.d = 12'h321; e.f = 1'b0;
    e.c = 3'd2; e.cy = acc + VALID_LAT;                    sb.push_back(e);
    e.c = 3'd3; e.cy = acc + FRAME_PERIOD + VALID_LAT;     sb.push_back(e);
    e.c = 3'd3; e.cy = acc + 2 * FRAME_PERIOD + VALID_LAT; sb.push_back(e);
    repeat (2 * FRAME_PERIOD) @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
    held_chk = 1'b0;
    chk("held_cs_falls", held_n, 3);

    // Leading bits 0100 flag a format error.
    start_frame(3'd7, 16'h4123, 12'h123, 3'd3, 1'b1, 1'b1, acc);

    // start and chan wiggled mid-frame must not disturb the frame or queue another.
    start_frame(3'd6, 16'h0ABC, 12'hABC, 3'd7, 1'b0, 1'b1, acc);
    repeat (20) @(negedge clk);
    falls0 = cs_falls;
    start = 1'b1; chan = 3'd1;
    @(negedge clk); chan = 3'd0;
    @(negedge clk); chan = 3'd5;
    @(negedge clk); start = 1'b0;
    wait_idle();
    repeat (10) @(negedge clk);
    chk("no_extra_frame_busy", busy, 0);
    chk("no_extra_frame_cs", cs_falls - falls0, 0);

    // Reset during bit 7 of a frame on channel 4.
    start_frame(3'd4, 16'h0555, 12'h555, 3'd6, 1'b0, 1'b0, acc);
    repeat (31) @(negedge clk);
    abort = 1'b1;
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_cs_n", ADC_CS_N, 1);
    chk("midrst_sclk", ADC_SCLK, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_data", data, 0);
    chk("midrst_data_chan", data_chan, 0);
    chk("midrst_valid", valid, 0);
    reset_n = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    busy_cnt = 0;

    start_frame(3'd1, 16'h0777, 12'h777, 3'd0, 1'b0, 1'b1, acc);

    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    chk("sclk_high_while_cs_high", sclk_viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
